spi_reg_slave: RTL and testbench

SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

---
 rtl/spi_reg_slave.sv | 128 ++++++++++++
 tb/tb_spi_reg_slave.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI mode-0 slave exposing 128 byte registers, with VERSION readable at 0x42.
// Define SPI_BURST_EN to keep streaming data bytes with an auto-incrementing (mod 128) address.
module spi_reg_slave #(
   parameter logic [7:0] VERSION     = 8'h12,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk_in,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       nss,
   input  logic       mosi,
   output logic       miso,
   output logic       wr_stb,
   output logic [6:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
   state_t state, state_nxt;
   logic [SYNC_STAGES-1:0] sclk_sy, nss_sy, mosi_sy;
   logic sclk_q, nss_q, sclk_s, nss_s, mosi_s;
   logic sclk_rise, sclk_fall, nss_rise, nss_fall, nss_edge;
   logic [2:0] bit_cnt;
   logic [6:0] shift_in, addr, addr_inc;
   logic [7:0] frame, shift_out;
   logic wnr, done, byte_done, commit;
   logic [7:0] regs [128];
   logic [127:0] vld;

   assign sclk_s    = sclk_sy[SYNC_STAGES-1];
   assign nss_s     = nss_sy[SYNC_STAGES-1];
   assign mosi_s    = mosi_sy[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_q;
   assign sclk_fall = ~sclk_s & sclk_q;
   assign nss_rise  = nss_s & ~nss_q;
   assign nss_fall  = ~nss_s & nss_q;
   assign nss_edge  = nss_rise | nss_fall;
   assign busy      = ~nss_s;
   assign frame     = {shift_in, mosi_s};
   assign addr_inc  = addr + 7'd1;
   assign byte_done = state == DATA && !done && sclk_rise && &bit_cnt && !nss_edge;
   assign commit    = byte_done && wnr && addr != 7'h42;

   // Registers never written since reset read as zero via the valid bits
   function automatic logic [7:0] rd(input logic [6:0] a);
      return (a == 7'h42) ? VERSION : (vld[a] ? regs[a] : 8'h00);
   endfunction

   always_ff @(posedge clk_in or negedge rst_n)
      if (!rst_n) begin
         sclk_sy <= '0;
         nss_sy  <= '1;
         mosi_sy <= '0;
         sclk_q  <= 1'b0;
         nss_q   <= 1'b1;
      end else begin
         sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], sclk};
         nss_sy  <= {nss_sy[SYNC_STAGES-2:0], nss};
         mosi_sy <= {mosi_sy[SYNC_STAGES-2:0], mosi};
         sclk_q  <= sclk_s;
         nss_q   <= nss_s;
      end

   always_ff @(posedge clk_in or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;

   always_comb begin
      state_nxt = state;
      if (nss_rise) state_nxt = IDLE;
      else if (nss_fall) state_nxt = ADDR;
      else if (state == ADDR && sclk_rise && &bit_cnt) state_nxt = DATA;
   end

   always_ff @(posedge clk_in)
      if (commit) regs[addr] <= frame;

   always_ff @(posedge clk_in or negedge rst_n)
      if (!rst_n) begin
         bit_cnt   <= 3'd0;
         shift_in  <= 7'd0;
         shift_out <= 8'd0;
         addr      <= 7'd0;
         wnr       <= 1'b0;
         done      <= 1'b0;
         miso      <= 1'b0;
         wr_stb    <= 1'b0;
         wr_addr   <= 7'd0;
         wr_data   <= 8'd0;
         vld       <= '0;
      end else begin
         wr_stb <= commit;
         if (commit) begin
            vld[addr] <= 1'b1;
            wr_addr   <= addr;
            wr_data   <= frame;
         end
         if (nss_edge) begin
            bit_cnt   <= 3'd0;
            shift_in  <= 7'd0;
            shift_out <= 8'd0;
            done      <= 1'b0;
            miso      <= 1'b0;
         end else if (state == ADDR && sclk_rise) begin
            shift_in <= frame[6:0];
            bit_cnt  <= bit_cnt + 3'd1;
            if (&bit_cnt) begin
               wnr       <= frame[7];
               addr      <= frame[6:0];
               shift_out <= frame[7] ? 8'h00 : rd(frame[6:0]);
            end
         end else if (state == DATA && !done && sclk_rise) begin
            shift_in <= frame[6:0];
            bit_cnt  <= bit_cnt + 3'd1;
`ifdef SPI_BURST_EN
            if (byte_done) begin
               addr      <= addr_inc;
               shift_out <= wnr ? 8'h00 : rd(addr_inc);
            end
`else
            if (byte_done) done <= 1'b1;
`endif
         end else if (state == DATA && sclk_fall) begin
            miso      <= (wnr || done) ? 1'b0 : shift_out[7];
            shift_out <= {shift_out[6:0], 1'b0};
         end
      end
endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: drives SPI frames into spi_reg_slave and checks writes and read-back bytes.
module tb_spi_reg_slave;
   logic clk_in = 1'b0, rst_n = 1'b0, sclk = 1'b0, nss = 1'b1, mosi = 1'b0;
   logic miso, wr_stb, busy;
   logic [6:0] wr_addr;
   logic [7:0] wr_data;
   int total = 0, bad = 0;
   logic [14:0] exp_q[$], obs_q[$];
   logic [7:0] mdl [128];
   logic [7:0] tx_b [4], rx_b [4];

   always #5 clk_in = ~clk_in;

   spi_reg_slave dut (
      .clk_in(clk_in), .rst_n(rst_n), .sclk(sclk), .nss(nss), .mosi(mosi),
      .miso(miso), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
   );

   always @(negedge clk_in) if (wr_stb === 1'b1) obs_q.push_back({wr_addr, wr_data});

   task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i > 7 - nb; i--) begin
         mosi = tx[i];
         #50;
         rx[i] = miso;
         sclk = 1'b1;
         #50;
         sclk = 1'b0;
      end
      mosi = 1'b0;
   endtask

   task automatic xfer(input int n, input int last_bits);
      logic [7:0] r;
      nss = 1'b0;
      #100;
      for (int b = 0; b < n; b++) begin
         spi_bits(tx_b[b], (b == n - 1) ? last_bits : 8, r);
         rx_b[b] = r;
      end
      #100;
      nss = 1'b1;
      #200;
   endtask

   task automatic check_writes(input string nm);
      logic [14:0] o, e;
      total++;
      if (obs_q.size() !== exp_q.size()) begin
         bad++;
         $display("FAIL %s wr_stb count got %0d want %0d", nm, obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL %s addr/data got %h/%h want %h/%h", nm, o[14:8], o[7:0], e[14:8], e[7:0]);
         end
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic do_write(input logic [6:0] a, input logic [7:0] d);
      if (a != 7'h42) begin
         exp_q.push_back({a, d});
         mdl[a] = d;
      end
      tx_b[0] = {1'b1, a};
      tx_b[1] = d;
      xfer(2, 8);
      total++;
      if ({rx_b[0], rx_b[1]} !== 16'h0000) begin
         bad++;
         $display("FAIL miso_on_write got %h want 0000", {rx_b[0], rx_b[1]});
      end
      check_writes("write");
   endtask

   task automatic do_read(input logic [6:0] a);
      logic [7:0] e;
      e = (a == 7'h42) ? 8'h12 : mdl[a];
      tx_b[0] = {1'b0, a};
      tx_b[1] = 8'h00;
      xfer(2, 8);
      total++;
      if ({rx_b[0], rx_b[1]} !== {8'h00, e}) begin
         bad++;
         $display("FAIL read_%h got %h want %h", a, {rx_b[0], rx_b[1]}, {8'h00, e});
      end
      check_writes("read");
   endtask

   task automatic check_idle_outputs(input string nm);
      total++;
      if ({miso, wr_stb, wr_addr, wr_data, busy} !== 18'h0) begin
         bad++;
         $display("FAIL %s outputs got miso=%b stb=%b addr=%h data=%h busy=%b want all 0",
                  nm, miso, wr_stb, wr_addr, wr_data, busy);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 128; i++) mdl[i] = 8'h00;
      rst_n = 1'b0;
      #20;
      check_idle_outputs("reset");
      rst_n = 1'b1;
      #100;
      check_idle_outputs("post_reset");
   endtask

   task automatic test_busy();
      nss = 1'b0;
      #100;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL busy_low got %b want 1", busy);
      end
      nss = 1'b1;
      #100;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL busy_high got %b want 0", busy);
      end
   endtask

   task automatic test_read();
      do_read(7'h42);
      do_read(7'h00);
      do_read(7'h05);
      do_read(7'h7F);
   endtask

   task automatic test_write();
      do_write(7'h05, 8'hA5);
      total++;
      if ({wr_addr, wr_data} !== {7'h05, 8'hA5}) begin
         bad++;
         $display("FAIL write_hold got %h/%h want 05/a5", wr_addr, wr_data);
      end
      do_read(7'h05);
      do_write(7'h06, 8'h3C);
   endtask

   task automatic test_write_version();
      do_write(7'h42, 8'h55);
      do_read(7'h42);
   endtask

   task automatic test_partial();
      tx_b[0] = 8'h90;
      tx_b[1] = 8'hAB;
      xfer(2, 4);
      check_writes("partial");
      do_read(7'h10);
   endtask

   task automatic test_burst();
      exp_q.push_back({7'h7F, 8'h11});
      mdl[7'h7F] = 8'h11;
`ifdef SPI_BURST_EN
      exp_q.push_back({7'h00, 8'h22});
      mdl[7'h00] = 8'h22;
`endif
      tx_b[0] = 8'hFF;
      tx_b[1] = 8'h11;
      tx_b[2] = 8'h22;
      xfer(3, 8);
      check_writes("burst_write");
      do_read(7'h7F);
      do_read(7'h00);
      tx_b[0] = 8'h05;
      tx_b[1] = 8'h00;
      tx_b[2] = 8'h00;
      xfer(3, 8);
      total++;
`ifdef SPI_BURST_EN
      if ({rx_b[1], rx_b[2]} !== {mdl[5], mdl[6]}) begin
         bad++;
         $display("FAIL burst_read got %h want %h", {rx_b[1], rx_b[2]}, {mdl[5], mdl[6]});
      end
`else
      if ({rx_b[1], rx_b[2]} !== {mdl[5], 8'h00}) begin
         bad++;
         $display("FAIL burst_read got %h want %h", {rx_b[1], rx_b[2]}, {mdl[5], 8'h00});
      end
`endif
      check_writes("burst_read");
   endtask

   task automatic test_reset_mid();
      logic [7:0] r;
      nss = 1'b0;
      #100;
      spi_bits(8'h81, 8, r);
      spi_bits(8'h5A, 4, r);
      rst_n = 1'b0;
      #20;
      check_idle_outputs("reset_mid");
      nss = 1'b1;
      #100;
      rst_n = 1'b1;
      #200;
      for (int i = 0; i < 128; i++) mdl[i] = 8'h00;
      check_writes("reset_mid");
      do_read(7'h01);
      do_read(7'h05);
      do_read(7'h42);
   endtask

   task automatic test_back_to_back();
      logic [6:0] as [6];
      logic [6:0] a;
      for (int i = 0; i < 6; i++) begin
         a = 7'($urandom_range(0, 127));
         if (a == 7'h42) a = 7'h43;
         as[i] = a;
         do_write(a, 8'($urandom));
      end
      for (int i = 0; i < 6; i++) do_read(as[i]);
   endtask

   initial begin
      test_reset();
      test_busy();
      test_read();
      test_write();
      test_write_version();
      test_partial();
      test_burst();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
